// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared states, timeout constant and width/saturation helpers for softmax_div_feeder
package softmax_pkg;

    typedef enum logic [3:0] {
        S_LOAD  = 4'b0001,
        S_SCALE = 4'b0010,
        S_ISSUE = 4'b0100,
        S_OUT   = 4'b1000
    } state_t;

    localparam int TIMEOUT_MULT = 2;

    function automatic int timeout_cycles(input int d_w);
        return TIMEOUT_MULT * d_w;
    endfunction

    // Wide enough that ROW_LEN non-negative scores can never overflow.
    function automatic int sum_width(input int d_w, input int row_len);
        return d_w - 1 + $clog2(row_len);
    endfunction

    // Clamp to the largest positive operand, and never hand the divider a zero.
    function automatic logic [31:0] sat_divisor(input logic [31:0] shifted, input int d_w);
        logic [31:0] max_v;
        max_v = (32'd1 << (d_w - 1)) - 32'd1;
        if (shifted > max_v) begin
            return max_v;
        end
        if (shifted == 32'd0) begin
            return 32'd1;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/softmax_row_buf.sv
// rtl/softmax_row_buf.sv - ROW_LEN x D_W row store, one synchronous write port, one combinational read port
module softmax_row_buf #(
    parameter int D_W     = 16,
    parameter int ROW_LEN = 8,
    parameter int IDX_W   = $clog2(ROW_LEN)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [D_W-1:0]   i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [D_W-1:0]   o_rd_data
);

    logic [D_W-1:0] r_mem [ROW_LEN];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/softmax_div_feeder.sv
// rtl/softmax_div_feeder.sv - row buffer, sum and divider sequencing for softmax; SOFTMAX_DIV_TIMEOUT_EN adds a divider timeout
module softmax_div_feeder
    import softmax_pkg::*;
#(
    parameter int D_W     = 16,
    parameter int ROW_LEN = 8,
    parameter int FRAC_W  = 8
) (
    input  logic           I_CLK,
    input  logic           I_RST,
    input  logic           I_IN_VLD,
    input  logic [D_W-1:0] I_IN_DATA,
    output logic           O_IN_RDY,
    output logic           O_DIV_START,
    output logic [D_W-1:0] O_DIV_DIVIDEND,
    output logic [D_W-1:0] O_DIV_DIVISOR,
    input  logic [D_W-1:0] I_DIV_QUOTIENT,
    input  logic           I_DIV_VLD,
    output logic           O_OUT_VLD,
    output logic [D_W-1:0] O_OUT_DATA,
    output logic           O_OUT_LAST,
    output logic           O_OUT_ERR,
    input  logic           I_OUT_RDY
);

    localparam int IDX_W = $clog2(ROW_LEN);
    localparam int SUM_W = sum_width(D_W, ROW_LEN);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [SUM_W-1:0] r_sum;
    logic [D_W-1:0]   r_div;
    logic [D_W-1:0]   r_out;
    logic [D_W-1:0]   w_clamped;
    logic [D_W-1:0]   w_rd_data;
    logic             w_in_fire;
    logic             w_last;
    logic             w_timeout;

    assign w_clamped = I_IN_DATA[D_W-1] ? '0 : I_IN_DATA;
    assign w_in_fire = I_IN_VLD && (r_state == S_LOAD);
    assign w_last    = (r_rd_idx == IDX_W'(ROW_LEN - 1));

    softmax_row_buf #(
        .D_W     (D_W),
        .ROW_LEN (ROW_LEN),
        .IDX_W   (IDX_W)
    ) u_row_buf (
        .i_clk     (I_CLK),
        .i_wr_en   (w_in_fire),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (w_clamped),
        .i_rd_idx  (r_rd_idx),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD:  if (w_in_fire && (r_wr_idx == IDX_W'(ROW_LEN - 1))) w_next_state = S_SCALE;
            S_SCALE: w_next_state = S_ISSUE;
            S_ISSUE: if (I_DIV_VLD || w_timeout) w_next_state = S_OUT;
            S_OUT:   if (I_OUT_RDY) w_next_state = w_last ? S_LOAD : S_ISSUE;
            default: w_next_state = S_LOAD;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_state  <= S_LOAD;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_sum    <= '0;
            r_div    <= '0;
            r_out    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_sum    <= r_sum + SUM_W'(w_clamped);
                        r_wr_idx <= r_wr_idx + IDX_W'(1);
                    end
                end
                S_SCALE: begin
                    r_div    <= D_W'(sat_divisor(32'(r_sum >> FRAC_W), D_W));
                    r_rd_idx <= '0;
                end
                S_ISSUE: begin
                    if (I_DIV_VLD) begin
                        r_out <= I_DIV_QUOTIENT;
                    end else if (w_timeout) begin
                        r_out <= '0;
                    end
                end
                S_OUT: begin
                    if (I_OUT_RDY) begin
                        if (w_last) begin
                            r_sum    <= '0;
                            r_wr_idx <= '0;
                        end else begin
                            r_rd_idx <= r_rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SOFTMAX_DIV_TIMEOUT_EN
    localparam int TO_CYC = timeout_cycles(D_W);
    localparam int TO_W   = $clog2(TO_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    assign w_timeout = (r_state == S_ISSUE) && !I_DIV_VLD && (r_to_cnt == TO_W'(TO_CYC - 1));

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == S_ISSUE) ? r_to_cnt + TO_W'(1) : '0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if ((r_state == S_OUT) && I_OUT_RDY) begin
                r_err <= 1'b0;
            end
        end
    end

    assign O_OUT_ERR = r_err && O_OUT_VLD;
`else
    assign w_timeout = 1'b0;
    assign O_OUT_ERR = 1'b0;
`endif

    // Dividend is gated so unreset buffer contents never appear outside a division.
    assign O_IN_RDY       = (r_state == S_LOAD);
    assign O_DIV_START    = (r_state == S_ISSUE);
    assign O_DIV_DIVIDEND = O_DIV_START ? w_rd_data : '0;
    assign O_DIV_DIVISOR  = r_div;
    assign O_OUT_VLD      = (r_state == S_OUT);
    assign O_OUT_DATA     = r_out;
    assign O_OUT_LAST     = O_OUT_VLD && w_last;

endmodule

// File: tb/tb_softmax_div_feeder.sv
// tb/tb_softmax_div_feeder.sv - directed and random rows against an arithmetic softmax-normalisation model
module tb_softmax_div_feeder;

    localparam int D_W     = 16;
    localparam int ROW_LEN = 4;
    localparam int FRAC_W  = 8;

    logic           clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_in_vld = 1'b0;
    logic [D_W-1:0] i_in_data = '0;
    logic           o_in_rdy;
    logic           o_div_start;
    logic [D_W-1:0] o_div_dividend;
    logic [D_W-1:0] o_div_divisor;
    logic [D_W-1:0] i_div_quotient = '0;
    logic           i_div_vld = 1'b0;
    logic           o_out_vld;
    logic [D_W-1:0] o_out_data;
    logic           o_out_last;
    logic           o_out_err;
    logic           i_out_rdy = 1'b0;

    int  vectors = 0;
    int  miscompares = 0;
    int  div_cnt = 0;
    bit  div_dead = 0;

    softmax_div_feeder #(.D_W(D_W), .ROW_LEN(ROW_LEN), .FRAC_W(FRAC_W)) dut (
        .I_CLK          (clk),
        .I_RST          (i_rst),
        .I_IN_VLD       (i_in_vld),
        .I_IN_DATA      (i_in_data),
        .O_IN_RDY       (o_in_rdy),
        .O_DIV_START    (o_div_start),
        .O_DIV_DIVIDEND (o_div_dividend),
        .O_DIV_DIVISOR  (o_div_divisor),
        .I_DIV_QUOTIENT (i_div_quotient),
        .I_DIV_VLD      (i_div_vld),
        .O_OUT_VLD      (o_out_vld),
        .O_OUT_DATA     (o_out_data),
        .O_OUT_LAST     (o_out_last),
        .O_OUT_ERR      (o_out_err),
        .I_OUT_RDY      (i_out_rdy)
    );

    initial forever #5 clk = ~clk;

    // Behavioural divider: done pulse in the 17th cycle of a held start.
    always @(negedge clk) begin
        int q;
        if (o_div_start === 1'b1) begin
            div_cnt = div_cnt + 1;
            if (div_cnt == D_W + 1 && !div_dead) begin
                q = (o_div_divisor == 0) ? 0 :
                    int'($signed(o_div_dividend)) / int'($signed(o_div_divisor));
                i_div_quotient = q[D_W-1:0];
                i_div_vld      = 1'b1;
            end else begin
                i_div_quotient = 16'hDEAD;
                i_div_vld      = 1'b0;
            end
        end else begin
            div_cnt   = 0;
            i_div_vld = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_row(input logic [D_W-1:0] row [ROW_LEN], output logic [D_W-1:0] c [ROW_LEN],
                           output logic [D_W-1:0] q [ROW_LEN], output logic [D_W-1:0] dvs);
        int s, d, v;
        s = 0;
        for (int i = 0; i < ROW_LEN; i++) begin
            v = int'($signed(row[i]));
            if (v < 0) v = 0;
            c[i] = v[D_W-1:0];
            s += v;
        end
        d = s / (1 << FRAC_W);
        if (d > 32767) d = 32767;
        if (d < 1) d = 1;
        dvs = d[D_W-1:0];
        for (int i = 0; i < ROW_LEN; i++) begin
            v = int'(c[i]) / d;
            q[i] = v[D_W-1:0];
        end
    endtask

    task automatic send_row(input logic [D_W-1:0] row [ROW_LEN]);
        int n;
        for (int i = 0; i < ROW_LEN; i++) begin
            i_in_vld  = 1'b1;
            i_in_data = row[i];
            n = 0;
            while (o_in_rdy !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (n >= 300) check("in_rdy_wait", {31'd0, o_in_rdy}, 32'd1);
            @(negedge clk);
        end
        i_in_vld = 1'b0;
    endtask

    task automatic recv_row(input logic [D_W-1:0] row [ROW_LEN], input int n_elems,
                            input int stall_elem, input int stall_cycles);
        logic [D_W-1:0] c [ROW_LEN];
        logic [D_W-1:0] q [ROW_LEN];
        logic [D_W-1:0] dvs;
        int n, starts;
        bit first;
        ref_row(row, c, q, dvs);
        for (int i = 0; i < n_elems; i++) begin
            n = 0;
            starts = 0;
            first = 1;
            while (o_out_vld !== 1'b1 && n < 300) begin
                if (o_div_start === 1'b1) begin
                    starts++;
                    if (first) begin
                        check($sformatf("dividend[%0d]", i), 32'(o_div_dividend), 32'(c[i]));
                        check($sformatf("divisor[%0d]", i), 32'(o_div_divisor), 32'(dvs));
                        first = 0;
                    end
                end
                @(negedge clk);
                n++;
            end
            check($sformatf("out_vld[%0d]", i), {31'd0, o_out_vld}, 32'd1);
            check($sformatf("start_len[%0d]", i), starts, D_W + 1);
            check($sformatf("out_data[%0d]", i), 32'(o_out_data), 32'(q[i]));
            check($sformatf("out_last[%0d]", i), {31'd0, o_out_last}, (i == ROW_LEN - 1) ? 32'd1 : 32'd0);
            check($sformatf("out_err[%0d]", i), {31'd0, o_out_err}, 32'd0);
            if (i == stall_elem) begin
                for (int k = 0; k < stall_cycles; k++) begin
                    @(negedge clk);
                    check("stall_data", 32'(o_out_data), 32'(q[i]));
                    check("stall_start", {31'd0, o_div_start}, 32'd0);
                    check("stall_vld", {31'd0, o_out_vld}, 32'd1);
                end
            end
            i_out_rdy = 1'b1;
            @(negedge clk);
            i_out_rdy = 1'b0;
        end
        if (n_elems == ROW_LEN) check("in_rdy_after_row", {31'd0, o_in_rdy}, 32'd1);
    endtask

    task automatic rand_row(output logic [D_W-1:0] row [ROW_LEN]);
        int v;
        for (int i = 0; i < ROW_LEN; i++) begin
            v = int'($urandom_range(0, 20000));
            if ($urandom_range(0, 3) == 0) v = -v;
            row[i] = v[D_W-1:0];
        end
    endtask

    initial begin
        logic [D_W-1:0] row [ROW_LEN];

        repeat (2) @(negedge clk);
        check("rst_in_rdy", {31'd0, o_in_rdy}, 32'd1);
        check("rst_start", {31'd0, o_div_start}, 32'd0);
        check("rst_out_vld", {31'd0, o_out_vld}, 32'd0);
        check("rst_outputs", {o_div_dividend, o_div_divisor}, 32'd0);
        check("rst_out_data", {14'd0, o_out_last, o_out_err, o_out_data}, 32'd0);
        i_rst = 1'b0;
        @(negedge clk);

        row = '{16'd256, 16'd256, 16'd256, 16'd256};
        send_row(row);
        recv_row(row, ROW_LEN, -1, 0);

        row = '{16'd512, 16'd0, 16'd0, 16'd0};
        send_row(row);
        recv_row(row, ROW_LEN, -1, 0);

        row = '{16'd10, 16'd20, 16'd30, 16'd40};
        send_row(row);
        recv_row(row, ROW_LEN, -1, 0);

        row = '{16'hFFFB, 16'd100, 16'd0, 16'd0};
        send_row(row);
        recv_row(row, ROW_LEN, -1, 0);

        // Backpressure on element 1, then reset in the middle of element 2's division.
        row = '{16'd3000, 16'd7000, 16'd1200, 16'd900};
        send_row(row);
        recv_row(row, 2, 1, 5);
        repeat (5) @(negedge clk);
        check("pre_rst_start", {31'd0, o_div_start}, 32'd1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("mid_rst_start", {31'd0, o_div_start}, 32'd0);
        check("mid_rst_in_rdy", {31'd0, o_in_rdy}, 32'd1);
        check("mid_rst_out_vld", {31'd0, o_out_vld}, 32'd0);

        for (int r = 0; r < 6; r++) begin
            rand_row(row);
            send_row(row);
            recv_row(row, ROW_LEN, (r == 2) ? 3 : -1, 3);
        end

        div_dead = 1;
        row = '{16'd256, 16'd512, 16'd768, 16'd1024};
        send_row(row);
`ifdef SOFTMAX_DIV_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (o_out_vld !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("to_latency", n, 2 * D_W + 1);
            check("to_out_vld", {31'd0, o_out_vld}, 32'd1);
            check("to_out_data", 32'(o_out_data), 32'd0);
            check("to_out_err", {31'd0, o_out_err}, 32'd1);
            check("to_start", {31'd0, o_div_start}, 32'd0);
            i_out_rdy = 1'b1;
            @(negedge clk);
            i_out_rdy = 1'b0;
            check("to_err_clear", {31'd0, o_out_err}, 32'd0);
        end
`else
        begin
            int bad_start, bad_vld;
            bad_start = 0;
            bad_vld = 0;
            repeat (3 * D_W) begin
                @(negedge clk);
                if (o_div_start !== 1'b1) bad_start++;
                if (o_out_vld !== 1'b0) bad_vld++;
            end
            check("noto_start_held", bad_start, 0);
            check("noto_no_vld", bad_vld, 0);
        end
`endif
        div_dead = 0;
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("final_rst_in_rdy", {31'd0, o_in_rdy}, 32'd1);

        rand_row(row);
        send_row(row);
        recv_row(row, ROW_LEN, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
